// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single downstream memory port between master 0
// (CPU) and master 1 (DMA/debug). One transaction is in flight at a time.
// A BUSY cycle counter bounds each access and turns a stall into an access
// fault.
// Build option: define MEM_ARB_ROUND_ROBIN_EN to alternate grants on a tie.
// Without it, master 0 always wins a tie.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,

    // master 0 (CPU)
    input  logic        m0_re,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wd,
    input  logic [1:0]  m0_rd_unit,
    input  logic [1:0]  m0_wd_unit,
    output logic [31:0] m0_rd,
    output logic        m0_done,
    output logic        m0_fault,

    // master 1 (secondary requester)
    input  logic        m1_re,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wd,
    input  logic [1:0]  m1_rd_unit,
    input  logic [1:0]  m1_wd_unit,
    output logic [31:0] m1_rd,
    output logic        m1_done,
    output logic        m1_fault,

    // downstream memory port
    output logic        s_re,
    output logic        s_we,
    output logic [31:0] s_addr,
    output logic [31:0] s_wd,
    output logic [1:0]  s_rd_unit,
    output logic [1:0]  s_wd_unit,
    input  logic [31:0] s_rd,
    input  logic        s_ready,
    input  logic        s_fault,

    // status
    output logic        busy,
    output logic        owner
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_t;

    // One extra bit so the counter can represent TIMEOUT itself without wrapping.
    localparam int unsigned  CW       = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] tmo_cnt;
    logic [CW-1:0] tmo_cnt_nxt;

    logic          req0;
    logic          req1;
    logic          grant;

    logic          sel_re;
    logic          sel_we;
    logic [31:0]   sel_addr;
    logic [31:0]   sel_wd;
    logic [1:0]    sel_rd_unit;
    logic [1:0]    sel_wd_unit;

    logic          owner_nxt;
    logic          busy_nxt;
    logic          s_re_nxt;
    logic          s_we_nxt;
    logic [31:0]   s_addr_nxt;
    logic [31:0]   s_wd_nxt;
    logic [1:0]    s_rd_unit_nxt;
    logic [1:0]    s_wd_unit_nxt;
    logic [31:0]   m0_rd_nxt;
    logic [31:0]   m1_rd_nxt;
    logic          m0_done_nxt;
    logic          m1_done_nxt;
    logic          m0_fault_nxt;
    logic          m1_fault_nxt;

    // Completion request raised by the state logic, routed to the owner below.
    logic          finish;
    logic          finish_fault;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic          last_served;
    logic          last_served_nxt;
`endif

    // Choose the master to serve when the port is free.
    always_comb begin
        req0 = m0_re | m0_we;
        req1 = m1_re | m1_we;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        grant = (req0 && req1) ? ~last_served : req1;
`else
        grant = req1 && !req0;
`endif
    end

    // Route the granted master's request fields toward the latch.
    always_comb begin
        if (grant) begin
            sel_re      = m1_re;
            sel_we      = m1_we;
            sel_addr    = m1_addr;
            sel_wd      = m1_wd;
            sel_rd_unit = m1_rd_unit;
            sel_wd_unit = m1_wd_unit;
        end else begin
            sel_re      = m0_re;
            sel_we      = m0_we;
            sel_addr    = m0_addr;
            sel_wd      = m0_wd;
            sel_rd_unit = m0_rd_unit;
            sel_wd_unit = m0_wd_unit;
        end
    end

    // Next state plus next value of every registered output.
    always_comb begin
        state_nxt     = state;
        tmo_cnt_nxt   = tmo_cnt;
        owner_nxt     = owner;
        s_re_nxt      = s_re;
        s_we_nxt      = s_we;
        s_addr_nxt    = s_addr;
        s_wd_nxt      = s_wd;
        s_rd_unit_nxt = s_rd_unit;
        s_wd_unit_nxt = s_wd_unit;
        m0_rd_nxt     = m0_rd;
        m1_rd_nxt     = m1_rd;
        m0_done_nxt   = 1'b0;
        m1_done_nxt   = 1'b0;
        m0_fault_nxt  = 1'b0;
        m1_fault_nxt  = 1'b0;
        finish        = 1'b0;
        finish_fault  = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_served_nxt = last_served;
`endif

        case (state)
            ST_IDLE: begin
                if (req0 || req1) begin
                    owner_nxt     = grant;
                    s_addr_nxt    = sel_addr;
                    s_wd_nxt      = sel_wd;
                    s_rd_unit_nxt = sel_rd_unit;
                    s_wd_unit_nxt = sel_wd_unit;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_served_nxt = grant;
`endif
                    if (sel_re && sel_we) begin
                        // Read and write together is illegal: fault without a slave access.
                        state_nxt    = ST_RESP;
                        finish       = 1'b1;
                        finish_fault = 1'b1;
                    end else begin
                        state_nxt   = ST_BUSY;
                        s_re_nxt    = sel_re;
                        s_we_nxt    = sel_we;
                        tmo_cnt_nxt = '0;
                    end
                end
            end

            ST_BUSY: begin
                tmo_cnt_nxt = tmo_cnt + 1'b1;
                if (s_ready) begin
                    state_nxt    = ST_RESP;
                    s_re_nxt     = 1'b0;
                    s_we_nxt     = 1'b0;
                    finish       = 1'b1;
                    finish_fault = s_fault;
                    if (s_re) begin
                        if (owner) begin
                            m1_rd_nxt = s_rd;
                        end else begin
                            m0_rd_nxt = s_rd;
                        end
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nxt    = ST_RESP;
                    s_re_nxt     = 1'b0;
                    s_we_nxt     = 1'b0;
                    finish       = 1'b1;
                    finish_fault = 1'b1;
                end
            end

            ST_RESP: begin
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
                s_re_nxt  = 1'b0;
                s_we_nxt  = 1'b0;
            end
        endcase

        if (finish) begin
            if (owner_nxt) begin
                m1_done_nxt  = 1'b1;
                m1_fault_nxt = finish_fault;
            end else begin
                m0_done_nxt  = 1'b1;
                m0_fault_nxt = finish_fault;
            end
        end

        busy_nxt = (state_nxt != ST_IDLE);
    end

    // Register state and outputs; reset aborts any transaction without a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            tmo_cnt   <= '0;
            owner     <= 1'b0;
            busy      <= 1'b0;
            s_re      <= 1'b0;
            s_we      <= 1'b0;
            s_addr    <= '0;
            s_wd      <= '0;
            s_rd_unit <= '0;
            s_wd_unit <= '0;
            m0_rd     <= '0;
            m1_rd     <= '0;
            m0_done   <= 1'b0;
            m1_done   <= 1'b0;
            m0_fault  <= 1'b0;
            m1_fault  <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_served <= 1'b1;
`endif
        end else begin
            state     <= state_nxt;
            tmo_cnt   <= tmo_cnt_nxt;
            owner     <= owner_nxt;
            busy      <= busy_nxt;
            s_re      <= s_re_nxt;
            s_we      <= s_we_nxt;
            s_addr    <= s_addr_nxt;
            s_wd      <= s_wd_nxt;
            s_rd_unit <= s_rd_unit_nxt;
            s_wd_unit <= s_wd_unit_nxt;
            m0_rd     <= m0_rd_nxt;
            m1_rd     <= m1_rd_nxt;
            m0_done   <= m0_done_nxt;
            m1_done   <= m1_done_nxt;
            m0_fault  <= m0_fault_nxt;
            m1_fault  <= m1_fault_nxt;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_served <= last_served_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: random master/slave traffic, a transaction-level
// reference model that predicts each completion, and a monitor that checks
// every done pulse against the predictions. Honours MEM_ARB_ROUND_ROBIN_EN.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int unsigned TIMEOUT = 16;

    logic        clk;
    logic        reset;
    logic        m0_re, m0_we, m1_re, m1_we;
    logic [31:0] m0_addr, m0_wd, m1_addr, m1_wd;
    logic [1:0]  m0_rd_unit, m0_wd_unit, m1_rd_unit, m1_wd_unit;
    logic [31:0] m0_rd, m1_rd;
    logic        m0_done, m0_fault, m1_done, m1_fault;
    logic        s_re, s_we;
    logic [31:0] s_addr, s_wd, s_rd;
    logic [1:0]  s_rd_unit, s_wd_unit;
    logic        s_ready, s_fault;
    logic        busy, owner;

    mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .m0_re(m0_re), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wd(m0_wd),
        .m0_rd_unit(m0_rd_unit), .m0_wd_unit(m0_wd_unit),
        .m0_rd(m0_rd), .m0_done(m0_done), .m0_fault(m0_fault),
        .m1_re(m1_re), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wd(m1_wd),
        .m1_rd_unit(m1_rd_unit), .m1_wd_unit(m1_wd_unit),
        .m1_rd(m1_rd), .m1_done(m1_done), .m1_fault(m1_fault),
        .s_re(s_re), .s_we(s_we), .s_addr(s_addr), .s_wd(s_wd),
        .s_rd_unit(s_rd_unit), .s_wd_unit(s_wd_unit),
        .s_rd(s_rd), .s_ready(s_ready), .s_fault(s_fault),
        .busy(busy), .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Expected completion of one transaction.
    typedef struct {
        logic        who;
        logic        fault;
        logic [31:0] rd0;
        logic [31:0] rd1;
        int          strobes;
        longint      done_cyc;
    } exp_t;

    // Slave behaviour for one granted access plus the fields it should see.
    typedef struct {
        logic        re;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [1:0]  rdu;
        logic [1:0]  wdu;
        int          w;
        logic [31:0] data;
        logic        f;
    } plan_t;

    exp_t  sb[$];
    plan_t sp[$];

    // Master agents: one outstanding transaction each.
    logic        pend  [2];
    logic        t_re  [2];
    logic        t_we  [2];
    logic [31:0] t_addr[2];
    logic [31:0] t_wd  [2];
    logic [1:0]  t_rdu [2];
    logic [1:0]  t_wdu [2];

    // Reference model state.
    longint      next_idle;
    logic [31:0] mrd[2];
`ifdef MEM_ARB_ROUND_ROBIN_EN
    int          last_served;
`endif

    // Slave agent state.
    plan_t cur;
    int    scnt = 0;

    function automatic int pick_wait();
        case ($urandom_range(7))
            0: return 0;
            1: return 1;
            2: return 2;
            3: return 3;
            4: return int'(TIMEOUT) - 2;
            5: return int'(TIMEOUT) - 1;
            6: return int'(TIMEOUT);
            default: return 999;
        endcase
    endfunction

    task automatic step(input int p);
        exp_t  e;
        plan_t pl;
        int    win;
        int    s;
        @(negedge clk);
        // Masters: retire on done, optionally issue a new transaction.
        for (int i = 0; i < 2; i++) begin
            if (pend[i] && ((i == 0 && m0_done) || (i == 1 && m1_done))) pend[i] = 1'b0;
            if (!pend[i] && int'($urandom_range(99)) < p) begin
                pend[i]   = 1'b1;
                s         = int'($urandom_range(9));
                t_re[i]   = (s < 5) || (s == 9);
                t_we[i]   = (s >= 5);
                t_addr[i] = $urandom;
                t_wd[i]   = $urandom;
                t_rdu[i]  = 2'($urandom_range(2));
                t_wdu[i]  = 2'($urandom_range(2));
            end
        end
        m0_re = pend[0] & t_re[0];  m0_we = pend[0] & t_we[0];
        m0_addr = t_addr[0]; m0_wd = t_wd[0]; m0_rd_unit = t_rdu[0]; m0_wd_unit = t_wdu[0];
        m1_re = pend[1] & t_re[1];  m1_we = pend[1] & t_we[1];
        m1_addr = t_addr[1]; m1_wd = t_wd[1]; m1_rd_unit = t_rdu[1]; m1_wd_unit = t_wdu[1];

        // Reference model: on a free port, grant and predict the whole transaction.
        if (cyc == next_idle) begin
            if (pend[0] || pend[1]) begin
                if (pend[0] && pend[1]) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    win = 1 - last_served;
`else
                    win = 0;
`endif
                end else begin
                    win = pend[1] ? 1 : 0;
                end
`ifdef MEM_ARB_ROUND_ROBIN_EN
                last_served = win;
`endif
                e.who = 1'(win);
                if (t_re[win] && t_we[win]) begin
                    e.fault   = 1'b1;
                    e.strobes = 0;
                end else begin
                    pl.re   = t_re[win];
                    pl.we   = t_we[win];
                    pl.addr = t_addr[win];
                    pl.wd   = t_wd[win];
                    pl.rdu  = t_rdu[win];
                    pl.wdu  = t_wdu[win];
                    pl.w    = pick_wait();
                    pl.data = $urandom;
                    pl.f    = 1'($urandom_range(1));
                    sp.push_back(pl);
                    if (pl.w < int'(TIMEOUT)) begin
                        e.strobes = pl.w + 1;
                        e.fault   = pl.f;
                        if (t_re[win]) mrd[win] = pl.data;
                    end else begin
                        e.strobes = int'(TIMEOUT);
                        e.fault   = 1'b1;
                    end
                end
                e.rd0      = mrd[0];
                e.rd1      = mrd[1];
                e.done_cyc = cyc + e.strobes + 1;
                next_idle  = e.done_cyc + 1;
                sb.push_back(e);
            end else begin
                next_idle = cyc + 1;
            end
        end

        // Slave: answer each strobed access according to its plan.
        if (s_re || s_we) begin
            if (scnt == 0) begin
                check("slave_plan_avail", (sp.size() > 0), 1);
                if (sp.size() > 0) begin
                    cur = sp.pop_front();
                    check("s_re_dir", s_re, cur.re);
                    check("s_we_dir", s_we, cur.we);
                    check("s_addr", s_addr, cur.addr);
                    check("s_wd", s_wd, cur.wd);
                    check("s_rd_unit", s_rd_unit, cur.rdu);
                    check("s_wd_unit", s_wd_unit, cur.wdu);
                end else begin
                    cur.w = 999;
                end
            end
            if (scnt == cur.w) begin
                s_ready = 1'b1;
                s_rd    = cur.data;
                s_fault = cur.f;
            end else begin
                s_ready = 1'b0;
                s_rd    = $urandom;
                s_fault = 1'($urandom_range(1));
            end
            scnt++;
        end else begin
            scnt    = 0;
            s_ready = 1'($urandom_range(1));
            s_rd    = $urandom;
            s_fault = 1'($urandom_range(1));
        end
    endtask

    // Monitor: every done pulse is matched against the oldest prediction.
    initial begin
        exp_t e;
        int   strobes_seen = 0;
        forever begin
            @(negedge clk);
            if (!busy) strobes_seen = 0;
            if (s_re || s_we) strobes_seen++;
            if (m0_done || m1_done) begin
                check("done_expected", (sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("done_single", m0_done & m1_done, 0);
                    check("done_who", m1_done, e.who);
                    check("fault", e.who ? m1_fault : m0_fault, e.fault);
                    check("m0_rd", m0_rd, e.rd0);
                    check("m1_rd", m1_rd, e.rd1);
                    check("owner", owner, e.who);
                    check("busy_in_resp", busy, 1);
                    check("strobe_cycles", strobes_seen, e.strobes);
                    check("done_cycle", 32'(cyc), 32'(e.done_cyc));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        m0_re = 0; m0_we = 0; m0_addr = '0; m0_wd = '0; m0_rd_unit = '0; m0_wd_unit = '0;
        m1_re = 0; m1_we = 0; m1_addr = '0; m1_wd = '0; m1_rd_unit = '0; m1_wd_unit = '0;
        s_rd = '0; s_ready = 1'b0; s_fault = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pend[i] = 1'b0; t_re[i] = 1'b0; t_we[i] = 1'b0; t_addr[i] = '0;
            t_wd[i] = '0; t_rdu[i] = '0; t_wdu[i] = '0; mrd[i] = '0;
        end

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_s_re", s_re, 0);
        check("rst_s_we", s_we, 0);
        check("rst_s_addr", s_addr, 0);
        check("rst_s_wd", s_wd, 0);
        check("rst_s_units", {s_rd_unit, s_wd_unit}, 0);
        check("rst_m0_rd", m0_rd, 0);
        check("rst_m1_rd", m1_rd, 0);
        check("rst_done_fault", {m0_done, m0_fault, m1_done, m1_fault}, 0);
        check("rst_busy", busy, 0);
        check("rst_owner", owner, 0);

        // Reset while BUSY aborts with no done pulse.
        reset   = 1'b0;
        m0_re   = 1'b1;
        m0_addr = 32'h0000_0100;
        @(negedge clk);
        check("abort_strobe_on", s_re, 1);
        check("abort_addr", s_addr, 32'h0000_0100);
        check("abort_busy_on", busy, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_s_re", s_re, 0);
        check("abort_s_we", s_we, 0);
        check("abort_busy", busy, 0);
        check("abort_no_done", m0_done, 0);
        reset   = 1'b0;
        m0_re   = 1'b0;
        m0_addr = '0;
        next_idle = cyc + 1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_served = 1;
`endif

        // Saturated traffic (ties every grant), then mixed, then drain.
        repeat (400)  step(100);
        repeat (2500) step(40);
        repeat (80)   step(0);
        check("scoreboard_drained", sb.size(), 0);
        check("slave_plans_drained", sp.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter sharing the core's single memory port between the CPU (master 0) and a secondary requester such as a DMA or debug module (master 1). It latches one request at a time, drives it onto the downstream memory port until the slave signals ready, then returns read data and completion status to the owning master. It enforces a bounded wait with a cycle timeout and reports that timeout as an access fault. It sits between `cpu` and the memory/MMIO decoder.

## Interface
- `TIMEOUT`, 16: cycles in BUSY before forced completion with fault; legal range ≥1.
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `m0_re`, `m0_we`  in  1 each  master 0 read/write request; level, held until `m0_done`
- `m0_addr`, `m0_wd`  in  32 each  master 0 address / write data
- `m0_rd_unit`, `m0_wd_unit`  in  2 each  access size: 0 byte, 1 half, 2 word
- `m0_rd`  out  32  read data for master 0; updated only on master 0 read completion
- `m0_done`  out  1  one-cycle completion pulse
- `m0_fault`  out  1  valid with `m0_done`; 1 = access fault
- `m1_*`  same set as `m0_*`, for master 1
- `s_re`, `s_we`  out  1 each  downstream read/write strobe
- `s_addr`, `s_wd`  out  32 each  downstream address / write data
- `s_rd_unit`, `s_wd_unit`  out  2 each  downstream access size
- `s_rd`  in  32  downstream read data, valid with `s_ready`
- `s_ready`  in  1  downstream completes the current access this cycle
- `s_fault`  in  1  downstream access fault, sampled only with `s_ready`
- `busy`  out  1  high in BUSY and RESP
- `owner`  out  1  index of the granted master; holds its last value in IDLE

## Operation
- States: IDLE, BUSY, RESP.
- **IDLE**
  - A master requests when `re|we` is high.
  - On a request, select the owner and latch addr, wd, units and direction into the `s_*` registers.
  - If the owner has `re&we` set, go directly to RESP with fault=1 and make no slave access.
  - Otherwise go to BUSY.
- **BUSY**
  - `s_re` or `s_we` is high and all `s_*` fields are stable.
  - The timeout counter clears on entry and increments each cycle.
  - If `s_ready` is sampled high: go to RESP, set fault=`s_fault`, and on a read capture `s_rd` into the owner's `mX_rd`.
  - Else, if counter = TIMEOUT-1: go to RESP with fault=1, leaving `mX_rd` unchanged.
  - `s_ready` takes priority over timeout on the same cycle.
- **RESP**
  - Owner's `mX_done`=1 and `mX_fault` is valid.
  - `s_re`=`s_we`=0.
  - No new grant this cycle. Go to IDLE next cycle.
- Master rule: drop the request in the cycle after `done`. Any request still high in the following IDLE cycle is a new transaction.
- `s_addr`, `s_wd` and the unit fields hold their last values outside BUSY. Only the strobes are gated.
- Tie (both masters request in IDLE): resolved as set under Configuration. A single requester is always granted.
- A non-owner's request is ignored while BUSY/RESP and is not lost. It stays pending at its input.

## Timing
- All outputs are registered.
- Reset values:
  - state=IDLE, `busy`=0, `owner`=0, last-served=1.
  - All `s_*`=0.
  - `mX_rd`=0, `mX_done`=0, `mX_fault`=0.
  - Timeout counter=0.
- Request seen in IDLE at cycle 0 → `s_re`/`s_we` high in cycle 1.
- `s_ready` high in cycle k → `done` in cycle k+1 → IDLE in cycle k+2.
- Zero-wait access: 3-cycle turnaround per transaction.
- Timeout with `s_ready` never high: strobe high for exactly TIMEOUT cycles, then `done`+fault.
- Illegal `re&we`: `done`+fault in cycle 1, no strobe.
- Reset mid-transaction: abort immediately, no `done` pulse, strobes low after the reset edge.
- Counter width is `$clog2(TIMEOUT)+1` and it does not wrap.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - On a tie, grant the master not equal to last-served.
  - Update last-served at each grant.
  - After reset, master 0 wins the first tie.
- Undefined:
  - Fixed priority: master 0 always wins ties.
  - Last-served register is absent.
  - Master 1 can starve under continuous master 0 traffic.

## Test plan
- m0 read addr 0x100, `s_ready` high in first BUSY cycle with `s_rd`=0xDEADBEEF → `s_re` for 1 cycle, `m0_done`=1 and `m0_rd`=0xDEADBEEF at cycle 2, `m1_rd` unchanged.
- m1 write addr 0x200, wd 0x55, unit 0, `s_ready` after 3 wait cycles → `s_we` high 4 cycles with `s_wd_unit`=0, `m1_done` with fault=0.
- Both masters request back-to-back for 4 transactions:
  - with `MEM_ARB_ROUND_ROBIN_EN` → owners 0,1,0,1;
  - without it → owners 0,0,0,0 while m0 keeps requesting.
- TIMEOUT=16, `s_ready` held low → strobe high exactly 16 cycles, `m0_done`+`m0_fault`=1, `m0_rd` retains its prior value.
- `s_ready`=1 with `s_fault`=1 on the TIMEOUT-1 cycle → fault=1 and `s_rd` captured on a read, i.e. the ready path is taken.
- m0 sets `re`=`we`=1 → `m0_done`+fault at cycle 1, `s_re`/`s_we` never high.
- Reset asserted during BUSY → next cycle: IDLE, strobes 0, no `done`.
